// File: rtl/zigzag_pkg.sv
// zigzag_pkg: shared FSM state type, default start token and index-width helper for the zigzag decryptor.
package zigzag_pkg;
  typedef enum logic [2:0] {COLLECT, COUNT, PREFIX, EMIT, DONE} state_t;
  localparam logic [7:0] START_TOKEN = 8'hFA;
  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/zigzag_rail_tracker.sv
// zigzag_rail_tracker: bouncing rail index 0..k_q-1, shared by the counting and emitting phases.
module zigzag_rail_tracker
  import zigzag_pkg::*;
#(
  parameter int MAX_KEY = 8,
  localparam int RW = $clog2(MAX_KEY),
  localparam int KW = idx_w(MAX_KEY)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          restart,
  input  logic          step,
  input  logic [KW-1:0] k_q,
  output logic [RW-1:0] r,
  output logic [RW-1:0] r_nxt
);
  logic down, down_nxt, at_bot, at_top;
  assign at_bot = KW'(r) == k_q - KW'(1);
  assign at_top = r == '0;
  always_comb begin
    r_nxt = r;
    down_nxt = down;
    if (restart) begin
      r_nxt = '0;
      down_nxt = 1'b1;
    end else if (step && k_q > KW'(1)) begin
      down_nxt = down ? !at_bot : at_top;
      r_nxt = down_nxt ? r + RW'(1) : r - RW'(1);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r <= '0;
      down <= 1'b1;
    end else begin
      r <= r_nxt;
      down <= down_nxt;
    end
endmodule

// File: rtl/zigzag_decryption_n.sv
// zigzag_decryption_n: buffered rail-fence decoder for keys 1..MAX_KEY with backpressured output.
// Optional err_o (dropped characters or clamped key) when ZIGZAG_DECRYPTION_ERR_EN is defined.
module zigzag_decryption_n
  import zigzag_pkg::*;
#(
  parameter int D_WIDTH = 8,
  parameter int KEY_WIDTH = 16,
  parameter int MAX_NOF_CHARS = 50,
  parameter int MAX_KEY = 8,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = D_WIDTH'(START_TOKEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key,
  input  logic                 ready_i,
  output logic                 busy,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o
`ifdef ZIGZAG_DECRYPTION_ERR_EN
  ,
  output logic                 err_o
`endif
);
  localparam int IW = idx_w(MAX_NOF_CHARS);
  localparam int AW = $clog2(MAX_NOF_CHARS);
  localparam int RW = $clog2(MAX_KEY);
  localparam int KW = idx_w(MAX_KEY);
  state_t state;
  logic [D_WIDTH-1:0] mem [MAX_NOF_CHARS];
  logic [IW-1:0] n, cnt;
  logic [IW-1:0] len [MAX_KEY];
  logic [IW-1:0] ptr [MAX_KEY];
  logic [RW-1:0] pi, r, r_nxt;
  logic [KW-1:0] k_q, k_nxt;
  logic [AW-1:0] nxt_idx;
  logic tok, wr, full, last_pre, accept, restart, step;
  assign full = n == IW'(MAX_NOF_CHARS);
  assign tok = state == COLLECT && valid_i && data_i == START_DECRYPTION_TOKEN;
  assign wr = state == COLLECT && valid_i && data_i != START_DECRYPTION_TOKEN && !full;
  assign k_nxt = key > KEY_WIDTH'(MAX_KEY) ? KW'(MAX_KEY) : key[KW-1:0];
  assign last_pre = state == PREFIX && pi == RW'(MAX_KEY - 1);
  assign accept = state == EMIT && valid_o && ready_i;
  assign restart = tok || last_pre;
  assign step = state == COUNT || accept;
  // In bypass the tracker never moves, so the next character is the same rail's next slot.
  assign nxt_idx = AW'(k_q <= KW'(1) ? ptr[r] + IW'(1) : ptr[r_nxt]);

  zigzag_rail_tracker #(.MAX_KEY(MAX_KEY)) u_trk (
    .clk(clk), .rst(rst), .restart(restart), .step(step), .k_q(k_q), .r(r), .r_nxt(r_nxt)
  );

  always_ff @(posedge clk)
    if (wr) mem[n[AW-1:0]] <= data_i;

`ifdef ZIGZAG_DECRYPTION_ERR_EN
  logic ovf;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ovf <= 1'b0;
      err_o <= 1'b0;
    end else begin
      err_o <= tok && (ovf || key > KEY_WIDTH'(MAX_KEY));
      ovf <= tok ? 1'b0 : ovf || (state == COLLECT && valid_i && !tok && full);
    end
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= COLLECT;
      busy <= 1'b0;
      valid_o <= 1'b0;
      data_o <= '0;
      n <= '0;
      cnt <= '0;
      pi <= '0;
      k_q <= '0;
      for (int j = 0; j < MAX_KEY; j++) begin
        len[j] <= '0;
        ptr[j] <= '0;
      end
    end else begin
      case (state)
        COLLECT: begin
          if (wr) n <= n + IW'(1);
          if (tok) begin
            k_q <= k_nxt;
            busy <= 1'b1;
            cnt <= '0;
            pi <= '0;
            for (int j = 0; j < MAX_KEY; j++) begin
              len[j] <= '0;
              ptr[j] <= '0;
            end
            if (n == '0) state <= DONE;
            else if (k_nxt <= KW'(1)) begin
              state <= EMIT;
              valid_o <= 1'b1;
              data_o <= mem[0];
            end else state <= COUNT;
          end
        end
        COUNT: begin
          len[r] <= len[r] + IW'(1);
          cnt <= cnt == n - IW'(1) ? '0 : cnt + IW'(1);
          if (cnt == n - IW'(1)) state <= PREFIX;
        end
        PREFIX: begin
          ptr[pi] <= pi == '0 ? '0 : ptr[pi - RW'(1)] + len[pi - RW'(1)];
          pi <= pi + RW'(1);
          if (last_pre) begin
            state <= EMIT;
            valid_o <= 1'b1;
            data_o <= mem[0];
          end
        end
        EMIT: begin
          if (accept) begin
            ptr[r] <= ptr[r] + IW'(1);
            cnt <= cnt + IW'(1);
            valid_o <= cnt != n - IW'(1);
            data_o <= cnt == n - IW'(1) ? '0 : mem[nxt_idx];
            if (cnt == n - IW'(1)) state <= DONE;
          end
        end
        DONE: begin
          busy <= 1'b0;
          n <= '0;
          state <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
endmodule

// File: tb/tb_zigzag_decryption_n.sv
// tb_zigzag_decryption_n: table-driven directed checks of the zigzag decryptor plus reset, empty and overflow sequences.
module tb_zigzag_decryption_n;
  localparam int MK = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] data_i = '0, data_i1 = '0;
  logic valid_i = 1'b0, valid_i1 = 1'b0, ready_i = 1'b1, ready_i1 = 1'b1;
  logic [15:0] key = '0, key1 = '0;
  logic busy, valid_o, busy1, valid_o1;
  logic [7:0] data_o, data_o1;
`ifdef ZIGZAG_DECRYPTION_ERR_EN
  logic err0, err1;
`endif
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  zigzag_decryption_n dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .key(key), .ready_i(ready_i),
    .busy(busy), .data_o(data_o), .valid_o(valid_o)
`ifdef ZIGZAG_DECRYPTION_ERR_EN
    , .err_o(err0)
`endif
  );

  zigzag_decryption_n #(.MAX_NOF_CHARS(4)) dut_s (
    .clk(clk), .rst(rst), .data_i(data_i1), .valid_i(valid_i1), .key(key1), .ready_i(ready_i1),
    .busy(busy1), .data_o(data_o1), .valid_o(valid_o1)
`ifdef ZIGZAG_DECRYPTION_ERR_EN
    , .err_o(err1)
`endif
  );

  typedef struct {
    int key;
    string ct;
    string pt;
    int stall;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic send(input string s, input int k);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      data_i = s[i];
      valid_i = 1'b1;
    end
    @(negedge clk);
    data_i = 8'hFA;
    key = 16'(k);
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    data_i = '0;
  endtask

  task automatic run_case(input int k, input string ct, input string pt, input int stall_at, input string nm);
    int n, got, cyc, first, bad;
    logic [7:0] held;
    bit stable;
    n = ct.len();
    got = 0;
    cyc = 1;
    first = -1;
    bad = 0;
    stable = 1'b1;
    held = '0;
    ready_i = 1'b1;
    send(ct, k);
    chk({nm, "_busy_t1"}, busy, 1);
    while (got < n && cyc < 500) begin
      if (valid_o && first < 0) first = cyc;
      if (valid_o && ready_i) begin
        if (data_o !== pt[got]) bad++;
        got++;
      end
      @(negedge clk);
      cyc++;
      if (stall_at >= 0 && got == stall_at && ready_i) begin
        ready_i = 1'b0;
        held = data_o;
        repeat (3) begin
          if (valid_o !== 1'b1 || data_o !== held) stable = 1'b0;
          @(negedge clk);
          cyc++;
        end
        ready_i = 1'b1;
        stall_at = -1;
        chk({nm, "_stall_char"}, held, pt[got]);
        chk({nm, "_stall_stable"}, stable, 1);
      end
    end
    chk({nm, "_first_valid"}, first, k <= 1 ? 1 : n + MK + 1);
    chk({nm, "_count"}, got, n);
    chk({nm, "_char_errs"}, bad, 0);
    chk({nm, "_done_valid"}, valid_o, 0);
    chk({nm, "_done_busy"}, busy, 1);
    @(negedge clk);
    chk({nm, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    vec_t tv[4];
    int w, got1, first1, bad1;
    string exp1;
    tv[0] = '{2, "HLOEL", "HELLO", -1};
    tv[1] = '{3, "WECRLTEERDSOEEFEAOCAIVDEN", "WEAREDISCOVEREDFLEEATONCE", -1};
    tv[2] = '{4, "AGBFCED", "ABCDEFG", 2};
    tv[3] = '{1, "XYZ", "XYZ", -1};
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_busy_small", busy1, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) run_case(tv[i].key, tv[i].ct, tv[i].pt, tv[i].stall, $sformatf("vec%0d", i));

    // Empty message: busy only during the DONE cycle, no output.
    send("", 3);
    chk("empty_busy_t1", busy, 1);
    chk("empty_valid_t1", valid_o, 0);
    @(negedge clk);
    chk("empty_busy_t2", busy, 0);
    chk("empty_valid_t2", valid_o, 0);

    // Reset in the middle of emission, then a clean message.
    send("HLOEL", 2);
    w = 0;
    while (!valid_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("midrst_valid_seen", valid_o, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_valid", valid_o, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_data", data_o, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_quiet", valid_o, 0);
    run_case(2, "HLOEL", "HELLO", -1, "after_rst");

    // Overflow and key clamp on the 4-deep instance: ABCDEF, key 9 -> ABCD.
    exp1 = "ABCD";
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      data_i1 = 8'(8'h41 + i);
      valid_i1 = 1'b1;
    end
    @(negedge clk);
    data_i1 = 8'hFA;
    key1 = 16'd9;
    @(negedge clk);
    valid_i1 = 1'b0;
    chk("ovf_busy_t1", busy1, 1);
`ifdef ZIGZAG_DECRYPTION_ERR_EN
    chk("ovf_err_pulse", err1, 1);
`endif
    got1 = 0;
    first1 = -1;
    bad1 = 0;
    w = 1;
    while (got1 < 4 && w < 200) begin
      if (valid_o1 && first1 < 0) first1 = w;
      if (valid_o1) begin
        if (data_o1 !== exp1[got1]) bad1++;
        got1++;
      end
      @(negedge clk);
      w++;
    end
`ifdef ZIGZAG_DECRYPTION_ERR_EN
    chk("ovf_err_cleared", err1, 0);
`endif
    chk("ovf_first_valid", first1, 4 + MK + 1);
    chk("ovf_count", got1, 4);
    chk("ovf_char_errs", bad1, 0);
    chk("ovf_done_valid", valid_o1, 0);
    @(negedge clk);
    chk("ovf_idle_busy", busy1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/zigzag_decryption_n.md
Name: zigzag_decryption_n

Overview:
- Parametrised successor to the fixed 2/3-rail zigzag decryptor.
- Buffers an encrypted message and decodes rail-fence ciphertext for any key from 1 to MAX_KEY.
- Emits plaintext one character per accepted handshake, with output backpressure.
- Sits between the input demux and the output mux; same START-token framing as the other decryption blocks.

Parameters:
- D_WIDTH, 8, character width.
- KEY_WIDTH, 16, key port width.
- MAX_NOF_CHARS, 50, message buffer depth.
- MAX_KEY, 8, largest supported rail count (>=2).
- START_DECRYPTION_TOKEN, 8'hFA, end-of-message/start-decrypt marker.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- data_i  in  D_WIDTH  encrypted character or START token.
- valid_i  in  1  data_i qualifier.
- key  in  KEY_WIDTH  rail count; sampled when the token is accepted.
- ready_i  in  1  downstream accepts data_o.
- busy  out  1  decoding/emitting in progress.
- data_o  out  D_WIDTH  decrypted character.
- valid_o  out  1  data_o qualifier.

Behaviour:
- Reset:
  - rst asserted asynchronously clears busy, valid_o, data_o (0), char count n, all rail lengths/pointers, and the latched key.
  - FSM goes to COLLECT.
  - Reset mid-operation aborts the message; no partial output follows.
- All outputs are registered.
- COLLECT:
  - valid_i with data_i != token: write buf[n], n++.
  - Writes with n == MAX_NOF_CHARS are dropped and n saturates.
  - valid_i with the token: latch key into k_q, then go to COUNT; busy=1 from the next cycle.
  - The token is never stored.
- Key handling:
  - k_q of 0 or 1: bypass mode, rail ptr[0]=0, jump straight to EMIT in plaintext = buffer order.
  - k_q > MAX_KEY is clamped to MAX_KEY.
- COUNT:
  - One position per cycle, p = 0..n-1.
  - Rail tracker r starts at 0, direction down; flips at r==k_q-1 and at r==0.
  - len[r]++ each cycle.
  - No modulo or divide hardware.
- PREFIX:
  - Fixed MAX_KEY cycles.
  - ptr[0]=0, ptr[i]=ptr[i-1]+len[i-1]; rails >= k_q get len 0.
- EMIT:
  - Rail tracker restarts at r=0, down.
  - Present buf[ptr[r]] on data_o with valid_o=1.
  - On valid_o && ready_i: ptr[r]++, advance r, count out++.
  - data_o/valid_o are held stable while ready_i=0.
  - After the n-th accepted character: valid_o=0, data_o=0, go to DONE.
- DONE (1 cycle): busy=0, n=0, go to COLLECT.
- n == 0 at the token: COUNT, PREFIX and EMIT are skipped; busy is high for exactly one cycle (DONE); no valid_o.
- Latency, token sampled at edge T:
  - busy=1 in cycle T+1.
  - First valid_o in cycle T+n+MAX_KEY+1 (T+1 in bypass).
  - Thereafter one character per cycle while ready_i=1.
- While busy, valid_i is ignored (characters and tokens dropped).
- Index counters are $clog2(MAX_NOF_CHARS+1) bits; ptr/len use the same width.
- No arithmetic overflow is possible given saturation of n.

Optional Feature:
- Macro ZIGZAG_DECRYPTION_ERR_EN.
- Defined: adds output port err_o (1 bit, reset 0). err_o pulses high for one cycle, the cycle after the token is accepted, if either:
  - characters were dropped due to a full buffer, or
  - key exceeded MAX_KEY.
  Decoding proceeds identically.
- Undefined: no err_o port, no sticky overflow flag; overflow and clamping are silent.

Decomposition:
- Shared package zigzag_pkg:
  - FSM state enum (COLLECT, COUNT, PREFIX, EMIT, DONE).
  - Default START_DECRYPTION_TOKEN constant.
  - Index-width function wrapping $clog2.
- Sub-module zigzag_rail_tracker:
  - Inputs: clk, rst, restart, step, k_q.
  - Output: rail r.
  - Instantiated once and reused by both COUNT and EMIT.

Test Plan:
- key=2, input "HLOEL" then FA, ready_i=1 -> output "HELLO", busy high T+1 to DONE.
- key=3, input "WECRLTEERDSOEEFEAOCAIVDEN" then FA -> "WEAREDISCOVEREDFLEEATONCE", 25 valid_o pulses.
- key=4, input "AGBFCED" then FA; ready_i toggled low 3 cycles after 2nd char -> "ABCDEFG", data_o stable while stalled.
- key=1, input "XYZ" then FA -> "XYZ", first valid_o at T+1.
- MAX_NOF_CHARS=4, key=9 with MAX_KEY=8, input 6 chars then FA -> 4 chars decoded with key 8 (pass-through order, since len > n); err_o pulse if ZIGZAG_DECRYPTION_ERR_EN is defined.
- rst asserted mid-EMIT -> valid_o/busy drop immediately; next message "HLOEL", key 2 decodes cleanly to "HELLO".
